// File: rtl/multiple_of_3_detector_fsm.sv
// multiple_of_3_detector_fsm: serial MSB-first divisibility-by-3 detector (Moore FSM)
//   clk   in  1  system clock, state updates on rising edge
//   reset in  1  asynchronous active-low reset, forces remainder 0
//   in    in  1  next serial bit, MSB first
//   out   out 1  1 when the number read so far is divisible by 3
module multiple_of_3_detector_fsm (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} state_t;
    state_t state;
    // state holds N mod 3; appending a bit gives rem' = (2*rem + in) mod 3
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S0;
        else begin
            case (state)
                S0:      state <= in ? S1 : S0;
                S1:      state <= in ? S0 : S2;
                S2:      state <= in ? S2 : S1;
                default: state <= S0;
            endcase
        end
    end
    // decoded from the state register only, so the illegal code 2'b11 reads as 0
    assign out = (state == S0);
endmodule

// File: tb/tb_multiple_of_3_detector_fsm.sv
// tb_multiple_of_3_detector_fsm: directed and random checks of the serial mod-3 detector
module tb_multiple_of_3_detector_fsm;
    logic clk, reset, in, out;
    int checks = 0;
    int errors = 0;

    multiple_of_3_detector_fsm dut (.clk(clk), .reset(reset), .in(in), .out(out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one bit away from the edge, then return 1 time unit after the sampling edge
    task automatic clock_bit(input logic b);
        in = b;
        @(posedge clk);
        #1;
    endtask

    // pulse reset low mid-cycle and check out rises without any clock edge
    task automatic async_reset(input string name);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL %s: out=%b expected 1 during async reset", name, out);
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clock_bit(i[0]);
            checks++;
            if (out !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold[%0d]: out=%b expected 1", i, out);
            end
        end
        #2 reset = 1'b1;
    endtask

    task automatic test_sequence();
        logic [9:0] bits = 10'b1001010101;
        logic [9:0] exp  = 10'b0001100001;
        async_reset("seq_reset");
        for (int i = 9; i >= 0; i--) begin
            clock_bit(bits[i]);
            checks++;
            if (out !== exp[i]) begin
                errors++;
                $display("FAIL seq_bit[%0d]: out=%b expected %b", 9 - i, out, exp[i]);
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [1:0] exp = 2'b01;
        async_reset("lz_reset");
        for (int i = 0; i < 4; i++) begin
            clock_bit(1'b0);
            checks++;
            if (out !== 1'b1) begin
                errors++;
                $display("FAIL leading_zero[%0d]: out=%b expected 1", i, out);
            end
        end
        for (int i = 1; i >= 0; i--) begin
            clock_bit(1'b1);
            checks++;
            if (out !== exp[i]) begin
                errors++;
                $display("FAIL lz_three[%0d]: out=%b expected %b", 1 - i, out, exp[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [2:0] bits = 3'b110;
        logic [2:0] exp  = 3'b011;
        async_reset("mid_pre_reset");
        clock_bit(1'b1);
        clock_bit(1'b0);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL mid_rem2: out=%b expected 0", out);
        end
        async_reset("mid_async");
        for (int i = 2; i >= 0; i--) begin
            clock_bit(bits[i]);
            checks++;
            if (out !== exp[i]) begin
                errors++;
                $display("FAIL mid_six[%0d]: out=%b expected %b", 2 - i, out, exp[i]);
            end
        end
    endtask

    task automatic test_all_ones();
        logic [5:0] exp = 6'b010101;
        async_reset("ones_reset");
        for (int i = 5; i >= 0; i--) begin
            clock_bit(1'b1);
            checks++;
            if (out !== exp[i]) begin
                errors++;
                $display("FAIL ones[%0d]: out=%b expected %b", 5 - i, out, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        int rem = 0;
        logic b;
        async_reset("rand_start");
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_reset");
                rem = 0;
            end
            b = 1'($urandom_range(0, 1));
            clock_bit(b);
            rem = (2 * rem + int'(b)) % 3;
            checks++;
            if (out !== (rem == 0)) begin
                errors++;
                $display("FAIL rand[%0d]: out=%b expected %b (rem %0d)", i, out, rem == 0, rem);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_leading_zeros();
        test_midstream_reset();
        test_all_ones();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
